line_buffer_ctrl: RTL and testbench
===================================

// Module: line_buffer_ctrl
// PURPOSE
//  Sequences a chain of WIN-1 shift_register line buffers (WIDTH=pixel, DEPTH=IMG_W) plus the WINxWIN
//  window registers for the minilab2 image-filter datapath.
//  Accepts a raster pixel stream (valid/ready) and drives the common i_shift enable.
//  Tracks the column/row position and flags when the window is fully populated, so the downstream
//  convolution can consume it.
//  Applies backpressure from the convolution back to the pixel source.
// PARAMETERS
//  IMG_W  640  pixels per row; also the line-buffer DEPTH
//  IMG_H  480  rows per frame
//  WIN    3    window edge (rows/cols that must be buffered); 2 <= WIN <= min(IMG_W,IMG_H)
// PORTS
//  i_clk         in   1              clock
//  i_rst_n       in   1              asynchronous active-low reset
//  i_start       in   1              one-cycle pulse; arms a new frame (honoured only in IDLE)
//  i_valid       in   1              source pixel valid
//  o_ready       out  1              controller can accept a pixel this cycle
//  o_shift       out  1              shift enable to every line buffer and window register
//  o_win_valid   out  1              window complete; held until i_out_ready
//  i_out_ready   in   1              convolution consumed the window
//  o_win_col     out  $clog2(IMG_W)  column of the newest pixel in the presented window
//  o_win_row     out  $clog2(IMG_H)  row of the newest pixel in the presented window
//  o_busy        out  1              state != IDLE
//  o_frame_done  out  1              one-cycle pulse when the last window of the frame is consumed
// BEHAVIOUR
//  - Reset (async): state=IDLE; col=row=0; all outputs 0.
//  - States:
//    - IDLE: i_start -> RUN.
//    - RUN: accepts pixels; on acceptance of pixel (IMG_H-1, IMG_W-1) -> DRAIN.
//    - DRAIN: when o_win_valid is 0, or o_win_valid && i_out_ready -> IDLE, with o_frame_done=1 that cycle.
//  - o_ready = (state==RUN) && !(o_win_valid && !i_out_ready). Combinational; no dependence on i_valid.
//  - Accept = i_valid && o_ready. o_shift = accept, combinational, so the datapath captures the pixel
//    on the same edge.
//  - Counters update on accept:
//    - col wraps IMG_W-1 -> 0, and row increments on that wrap.
//    - row is not wrapped; DRAIN/IDLE clears both counters.
//  - Window qualifies when the accepted pixel has row >= WIN-1 and col >= WIN-1.
//    - The next cycle: o_win_valid=1, and o_win_col/o_win_row = that pixel's position
//      (1-cycle latency, registered).
//  - o_win_valid is cleared on i_out_ready unless a new qualifying pixel is accepted the same cycle;
//    in that case it stays 1 with the new coordinates.
//  - Full throughput: 1 pixel/cycle when i_out_ready is held high.
//  - i_start outside IDLE is ignored. i_valid outside RUN is ignored (no shift).
//  - Windows that straddle a row wrap (col < WIN-1) are never flagged.
//  - Reset mid-frame aborts immediately to IDLE, with no o_frame_done. Line buffers are reset by the
//    same i_rst_n.
// CONFIGURATION
//  LINE_BUFFER_CTRL_STALL_CNT_EN
//    - Defined: adds output o_stall_cnt[15:0], counting cycles with i_valid && !o_ready while in RUN.
//      Saturates at 16'hFFFF, clears on an accepted i_start, resets to 0.
//    - Undefined: the port and logic are absent; behaviour is otherwise identical.
// STRUCTURE
//  - Package line_buffer_ctrl_pkg: lbc_state_e {IDLE, RUN, DRAIN} and localparam STALL_W=16.
//  - Counter widths are derived locally via $clog2.
//  - Sub-module wrap_counter #(MAX) (inc, clr, value, wrap), instantiated for col and row.
//  - The controller does not instantiate shift_register; the top level connects o_shift.
// TESTING (IMG_W=4, IMG_H=4, WIN=3 unless noted)
//  - i_start, then 16 back-to-back pixels with i_out_ready=1:
//    - exactly 16 o_shift pulses.
//    - o_win_valid on the cycle after pixel #10, #11, #14, #15, with (col,row) = (2,2), (3,2), (2,3), (3,3).
//    - o_frame_done 1 cycle after the last window.
//  - Hold i_out_ready=0 after the first window: o_ready=0, no further o_shift, o_win_valid stays at (2,2).
//    Release: streaming resumes with no lost or duplicated window.
//  - i_start pulsed mid-frame, and i_valid while IDLE: no state change, no o_shift.
//  - Assert i_rst_n=0 after pixel #7: all outputs 0 asynchronously, state=IDLE.
//    A new frame then produces the same 4 windows.
//  - Random i_valid/i_out_ready gaps over 3 frames: total windows = 12 and total o_shift = 48.
//    With LINE_BUFFER_CTRL_STALL_CNT_EN, o_stall_cnt equals the count of stalled-valid cycles in
//    the last frame.

Source files
------------

// File: rtl/line_buffer_ctrl_pkg.sv
// ============================================================================
// Module  : line_buffer_ctrl_pkg
// Brief   : Shared state encoding and widths for the line-buffer controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

package line_buffer_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } lbc_state_e;

  localparam int STALL_W = 16;

endpackage

`default_nettype wire

// File: rtl/line_buffer_ctrl_wrap.sv
// ============================================================================
// Module  : wrap_counter
// Brief   : Modulo-MAX up-counter with synchronous clear and a wrap strobe.
// Revision: 1.0
// ============================================================================
`default_nettype none

module wrap_counter #(
  parameter  int MAX = 4,
  localparam int W   = (MAX > 1) ? $clog2(MAX) : 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value,
  output logic         wrap
);

  localparam logic [W-1:0] C_LAST = W'(MAX - 1);

  assign wrap = inc && (value == C_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc) begin
      value <= wrap ? '0 : value + W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/line_buffer_ctrl.sv
// ============================================================================
// Module  : line_buffer_ctrl
// Brief   : Raster-stream sequencer for the line buffers and window registers;
//           optional stall counter enabled by LINE_BUFFER_CTRL_STALL_CNT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module line_buffer_ctrl
  import line_buffer_ctrl_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int WIN   = 3
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic                     o_shift,
  output logic                     o_win_valid,
  input  logic                     i_out_ready,
  output logic [$clog2(IMG_W)-1:0] o_win_col,
  output logic [$clog2(IMG_H)-1:0] o_win_row,
  output logic                     o_busy,
  output logic                     o_frame_done
`ifdef LINE_BUFFER_CTRL_STALL_CNT_EN
  ,
  output logic [STALL_W-1:0]       o_stall_cnt
`endif
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  localparam logic [COL_W-1:0] C_COL_MIN = COL_W'(WIN - 1);
  localparam logic [ROW_W-1:0] C_ROW_MIN = ROW_W'(WIN - 1);

  lbc_state_e       r_state;
  lbc_state_e       w_state_nxt;
  logic [COL_W-1:0] w_col;
  logic [ROW_W-1:0] w_row;
  logic             w_col_wrap;
  logic             w_row_wrap;
  logic             w_accept;
  logic             w_cnt_clr;
  logic             w_qualify;
  logic             r_win_valid;
  logic [COL_W-1:0] r_win_col;
  logic [ROW_W-1:0] r_win_row;

  // A presented window that has not been taken blocks the whole stream.
  assign o_ready   = (r_state == RUN) && !(r_win_valid && !i_out_ready);
  assign w_accept  = i_valid && o_ready;
  assign o_shift   = w_accept;
  assign w_cnt_clr = (r_state != RUN);
  assign w_qualify = w_accept && (w_col >= C_COL_MIN) && (w_row >= C_ROW_MIN);

  wrap_counter #(
    .MAX (IMG_W)
  ) u_col_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .inc     (w_accept),
    .clr     (w_cnt_clr),
    .value   (w_col),
    .wrap    (w_col_wrap)
  );

  // The row wrap strobe coincides with acceptance of the frame's last pixel.
  wrap_counter #(
    .MAX (IMG_H)
  ) u_row_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .inc     (w_accept && w_col_wrap),
    .clr     (w_cnt_clr),
    .value   (w_row),
    .wrap    (w_row_wrap)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    o_frame_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (w_row_wrap) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (!r_win_valid || i_out_ready) begin
          w_state_nxt  = IDLE;
          o_frame_done = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_win_valid <= 1'b0;
      r_win_col   <= '0;
      r_win_row   <= '0;
    end else if (w_qualify) begin
      r_win_valid <= 1'b1;
      r_win_col   <= w_col;
      r_win_row   <= w_row;
    end else if (i_out_ready) begin
      r_win_valid <= 1'b0;
    end
  end

  assign o_win_valid = r_win_valid;
  assign o_win_col   = r_win_col;
  assign o_win_row   = r_win_row;
  assign o_busy      = (r_state != IDLE);

`ifdef LINE_BUFFER_CTRL_STALL_CNT_EN
  logic [STALL_W-1:0] r_stall_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt <= '0;
    end else if ((r_state == IDLE) && i_start) begin
      r_stall_cnt <= '0;
    end else if ((r_state == RUN) && i_valid && !o_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + STALL_W'(1);
    end
  end

  assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_line_buffer_ctrl.sv
// ============================================================================
// Module  : tb_line_buffer_ctrl
// Brief   : Self-checking bench for line_buffer_ctrl (4x4 image, 3x3 window).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_line_buffer_ctrl;

  localparam int IMG_W = 4;
  localparam int IMG_H = 4;
  localparam int WIN   = 3;
  localparam int NPIX  = IMG_W * IMG_H;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       ready, shift, win_valid, busy, frame_done;
  logic [1:0] win_col, win_row;
`ifdef LINE_BUFFER_CTRL_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  line_buffer_ctrl #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .WIN   (WIN)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_valid      (valid),
    .o_ready      (ready),
    .o_shift      (shift),
    .o_win_valid  (win_valid),
    .i_out_ready  (out_ready),
    .o_win_col    (win_col),
    .o_win_row    (win_row),
    .o_busy       (busy),
    .o_frame_done (frame_done)
`ifdef LINE_BUFFER_CTRL_STALL_CNT_EN
    ,
    .o_stall_cnt  (stall_cnt)
`endif
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level model: pixel index in frame, pending window, stall tally.
  bit m_active = 0;
  int m_n = 0;
  bit m_wv = 0;
  int m_wc = 0, m_wr = 0;
  int m_stall = 0;
  bit e_ready, e_shift, e_done;
  int pc, pr;

  int shift_cnt = 0, win_cnt = 0, done_cnt = 0;
  int log_col[$];
  int log_row[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ready", ready, 0);
      chk("rst_shift", shift, 0);
      chk("rst_win_valid", win_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_win_col", win_col, 0);
      chk("rst_win_row", win_row, 0);
`ifdef LINE_BUFFER_CTRL_STALL_CNT_EN
      chk("rst_stall_cnt", stall_cnt, 0);
`endif
      m_active = 0; m_n = 0; m_wv = 0; m_stall = 0;
    end else begin
      e_ready = m_active && (m_n < NPIX) && !(m_wv && !out_ready);
      e_shift = valid && e_ready;
      e_done  = m_active && (m_n == NPIX) && (!m_wv || out_ready);
      chk("ready", ready, e_ready);
      chk("shift", shift, e_shift);
      chk("win_valid", win_valid, m_wv);
      chk("busy", busy, m_active);
      chk("frame_done", frame_done, e_done);
      if (m_wv) begin
        chk("win_col", win_col, m_wc);
        chk("win_row", win_row, m_wr);
      end
`ifdef LINE_BUFFER_CTRL_STALL_CNT_EN
      chk("stall_cnt", stall_cnt, m_stall);
`endif
      if (shift) shift_cnt++;
      if (win_valid && out_ready) begin
        win_cnt++;
        log_col.push_back(int'(win_col));
        log_row.push_back(int'(win_row));
      end
      if (frame_done) done_cnt++;

      if (!m_active && start) m_stall = 0;
      else if (m_active && (m_n < NPIX) && valid && !e_ready && m_stall < 65535) m_stall++;

      if (e_shift) begin
        pc = m_n % IMG_W;
        pr = m_n / IMG_W;
        m_n++;
        if (pc >= WIN - 1 && pr >= WIN - 1) begin
          m_wv = 1; m_wc = pc; m_wr = pr;
        end else if (out_ready) begin
          m_wv = 0;
        end
      end else if (out_ready) begin
        m_wv = 0;
      end

      if (!m_active) begin
        if (start) begin m_active = 1; m_n = 0; end
      end else if (e_done) begin
        m_active = 0;
      end
    end
  end

  task automatic cyc(input logic v, input logic r, input logic s);
    valid = v; out_ready = r; start = s;
    @(posedge clk); #1;
  endtask

  task automatic run_to_done(input int budget);
    int d0;
    int k;
    d0 = done_cnt;
    k = 0;
    while (done_cnt == d0 && k < budget) begin
      cyc(1'b1, 1'b1, 1'b0);
      k++;
    end
    chk("frame_done_within_budget", (done_cnt != d0), 1);
  endtask

  task automatic chk_windows(input string nm);
    int ec[4];
    int er[4];
    ec = '{2, 3, 2, 3};
    er = '{2, 2, 3, 3};
    chk({nm, "_count"}, log_col.size(), 4);
    for (int i = 0; i < 4 && i < log_col.size(); i++) begin
      chk({nm, "_col"}, log_col[i], ec[i]);
      chk({nm, "_row"}, log_row[i], er[i]);
    end
  endtask

  int s0, w0, d0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy_literal", busy, 0);
    chk("reset_win_valid_literal", win_valid, 0);
    rst_n = 1'b1;
    cyc(0, 0, 0);

    // Back-to-back frame
    log_col.delete(); log_row.delete();
    s0 = shift_cnt; d0 = done_cnt;
    cyc(0, 1, 1);
    for (int i = 0; i < NPIX; i++) cyc(1, 1, 0);
    chk("stream_done_pending", done_cnt - d0, 0);
    cyc(0, 1, 0);
    chk("stream_done_one_after_last", done_cnt - d0, 1);
    chk("stream_shifts", shift_cnt - s0, 16);
    chk_windows("stream_windows");
    repeat (2) cyc(0, 1, 0);

    // Valid while idle does nothing
    s0 = shift_cnt;
    repeat (3) cyc(1, 1, 0);
    chk("idle_valid_no_shift", shift_cnt - s0, 0);
    chk("idle_valid_not_busy", busy, 0);

    // Backpressure after the first window, plus a mid-frame start
    log_col.delete(); log_row.delete();
    cyc(0, 1, 1);
    for (int i = 0; i < 4; i++) cyc(1, 1, 0);
    s0 = shift_cnt;
    cyc(0, 1, 1);
    chk("midframe_start_busy", busy, 1);
    chk("midframe_start_no_shift", shift_cnt - s0, 0);
    for (int i = 4; i < 11; i++) cyc(1, 1, 0);
    s0 = shift_cnt;
    for (int i = 0; i < 5; i++) cyc(1, 0, 0);
    chk("bp_no_shift", shift_cnt - s0, 0);
    chk("bp_ready_low", ready, 0);
    chk("bp_win_valid", win_valid, 1);
    chk("bp_win_col", win_col, 2);
    chk("bp_win_row", win_row, 2);
    run_to_done(40);
    chk_windows("bp_windows");
    repeat (2) cyc(0, 1, 0);

    // Async reset after 7 pixels, then a clean frame
    cyc(0, 1, 1);
    for (int i = 0; i < 7; i++) cyc(1, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_ready", ready, 0);
    chk("async_rst_shift", shift, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(0, 0, 0);
    log_col.delete(); log_row.delete();
    cyc(0, 1, 1);
    run_to_done(40);
    chk_windows("after_rst_windows");
    repeat (2) cyc(0, 1, 0);

    // Random gaps over 3 frames
    s0 = shift_cnt; w0 = win_cnt;
    for (int f = 0; f < 3; f++) begin
      d0 = done_cnt;
      cyc(0, 1, 1);
      for (int k = 0; k < 600 && done_cnt == d0; k++)
        cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      chk("rand_frame_done", done_cnt - d0, 1);
      cyc(0, 0, 0);
    end
    chk("rand_total_windows", win_cnt - w0, 12);
    chk("rand_total_shifts", shift_cnt - s0, 48);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
